// File: rtl/crypt_arith_pkg.sv
// Shared arithmetic package: FSM state encoding and width-derivation helpers for the
// digit-serial resolver.
package crypt_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } resolve_state_e;

    function automatic int ceil_div(int a, int b);
        return (a + b - 1) / b;
    endfunction

    // Counter width; at least one bit so a single-chunk build still has a legal vector.
    function automatic int cnt_width(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/csa_resolve_chunk.sv
// Combinational CHUNK-bit adder with carry in/out; a plain '+' so synthesis maps it
// onto the dedicated carry chain.
module csa_resolve_chunk #(
    parameter int unsigned CHUNK = 32
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] sum,
    output logic             co
);

    localparam int unsigned SW = CHUNK + 1;

    assign {co, sum} = SW'(a) + SW'(b) + SW'(ci);

endmodule

// File: rtl/csa_resolve_serial.sv
// Digit-serial carry-propagate resolver: turns a redundant (sum, carry) pair into a W+1-bit
// binary result, CHUNK bits per cycle. Optional zero-detect early exit: CSA_RESOLVE_EARLYEXIT_EN.
module csa_resolve_serial
    import crypt_arith_pkg::*;
#(
    parameter int unsigned W     = 224,
    parameter int unsigned CHUNK = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_s,
    input  logic [W-1:0] in_c,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   out_res,
    output logic         busy
);

    localparam int unsigned NCHUNK = ceil_div(W, CHUNK);
    localparam int unsigned CW     = cnt_width(NCHUNK);

    if ((W % CHUNK) != 0) begin : g_width_check
        $error("csa_resolve_serial: W must be a multiple of CHUNK");
    end

    resolve_state_e state, state_d;

    logic [W-1:0]    s_q, c_q, s_d, c_d;
    logic [W:0]      res_q, res_d;
    logic            carry_q, carry_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            out_valid_d, in_ready_d, busy_d;

    logic [CHUNK-1:0] sum_c;
    logic             co_c;
    logic [W-1:0]     s_shift_c, c_shift_c;
    logic             last_chunk_c, run_last_c;

    csa_resolve_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a   (s_q[CHUNK-1:0]),
        .b   (c_q[CHUNK-1:0]),
        .ci  (carry_q),
        .sum (sum_c),
        .co  (co_c)
    );

    assign s_shift_c    = s_q >> CHUNK;
    assign c_shift_c    = c_q >> CHUNK;
    assign last_chunk_c = (cnt_q == CW'(NCHUNK - 1));

`ifdef CSA_RESOLVE_EARLYEXIT_EN
    // Nothing left to add and no carry pending: remaining chunks are already zero.
    assign run_last_c = last_chunk_c || (!co_c && (s_shift_c == '0) && (c_shift_c == '0));
`else
    assign run_last_c = last_chunk_c;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (in_valid)   state_d = RUN;
            RUN:     if (run_last_c) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        s_d         = s_q;
        c_d         = c_q;
        res_d       = res_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        case (state)
            IDLE: begin
                if (in_valid) begin
                    s_d     = in_s;
                    c_d     = in_c;
                    res_d   = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                res_d[cnt_q*CHUNK +: CHUNK] = sum_c;
                if (last_chunk_c) res_d[W] = co_c;
                s_d     = s_shift_c;
                c_d     = c_shift_c;
                carry_d = co_c;
                cnt_d   = cnt_q + CW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q       <= '0;
            c_q       <= '0;
            res_q     <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            s_q       <= s_d;
            c_q       <= c_d;
            res_q     <= res_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            out_valid <= out_valid_d;
            in_ready  <= in_ready_d;
            busy      <= busy_d;
        end
    end

    assign out_res = res_q;

endmodule

// File: tb/tb_csa_resolve_serial.sv
// Directed self-checking bench for csa_resolve_serial (default W=224, CHUNK=32); latency
// expectations follow CSA_RESOLVE_EARLYEXIT_EN when the bench is built with it.
module tb_csa_resolve_serial;

    localparam int unsigned W = 224;

`ifdef CSA_RESOLVE_EARLYEXIT_EN
    localparam int LAT_SMALL = 1;
    localparam int LAT_B100  = 4;
`else
    localparam int LAT_SMALL = 7;
    localparam int LAT_B100  = 7;
`endif
    localparam int LAT_FULL = 7;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_s;
    logic [W-1:0] in_c;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   out_res;
    logic         busy;

    int checks = 0;
    int errors = 0;

    csa_resolve_serial #(.W(W), .CHUNK(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_s      (in_s),
        .in_c      (in_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, req);
        end
    endtask

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] r;
        for (int i = 0; i < 7; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // One full transaction; exp_lat < 0 skips the latency comparison.
    task automatic do_op(input logic [W-1:0] s, input logic [W-1:0] c, input int hold,
                         input int exp_lat, input bit poke, input string tag);
        logic [W:0] exp_v;
        int n;
        exp_v = {1'b0, s} + {1'b0, c};
        in_s = s;
        in_c = c;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin step(); n++; end
        chk({tag, "_ready"}, (W+1)'(in_ready), (W+1)'(1));
        step();
        in_valid = 1'b0;
        in_s = ~s;
        in_c = ~c;
        chk({tag, "_busy"}, (W+1)'(busy), (W+1)'(1));
        n = 0;
        while (!out_valid && n < 50) begin step(); n++; end
        if (exp_lat >= 0) chk({tag, "_lat"}, (W+1)'(n), (W+1)'(exp_lat));
        chk({tag, "_res"}, out_res, exp_v);
        for (int i = 0; i < hold; i++) begin
            in_valid = poke;
            step();
            chk({tag, "_hold_valid"}, (W+1)'(out_valid), (W+1)'(1));
            chk({tag, "_hold_res"}, out_res, exp_v);
            chk({tag, "_hold_ready"}, (W+1)'(in_ready), (W+1)'(0));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_hs_valid"}, (W+1)'(out_valid), (W+1)'(0));
        chk({tag, "_hs_ready"}, (W+1)'(in_ready), (W+1)'(1));
    endtask

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] s, c, b100;
        logic [W:0]   exp3;
        int n;

        ones = '1;
        b100 = '0;
        b100[100] = 1'b1;
        exp3 = '1;
        exp3[0] = 1'b0;

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_s = '0;
        in_c = '0;
        out_ready = 1'b0;
        repeat (2) step();
        @(negedge clk) rst_n = 1'b1;
        step();
        chk("rst_valid", (W+1)'(out_valid), '0);
        chk("rst_res", out_res, '0);
        chk("rst_ready", (W+1)'(in_ready), (W+1)'(1));
        chk("rst_busy", (W+1)'(busy), '0);

        // Small sums, full ripple, held output with ignored in_valid
        do_op(W'(1), W'(2), 0, LAT_SMALL, 1'b0, "t1");
        do_op(ones, W'(1), 0, LAT_FULL, 1'b0, "t2");
        chk("t2_top", (W+1)'(out_res[W]), (W+1)'(1));
        do_op(ones, ones, 5, LAT_FULL, 1'b1, "t3");
        chk("t3_res_after_hs", out_res, exp3);

        // Reset in the third RUN cycle discards the operation
        in_s = ones;
        in_c = W'(1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("t4_rst_valid", (W+1)'(out_valid), '0);
        chk("t4_rst_res", out_res, '0);
        @(negedge clk) rst_n = 1'b1;
        step();
        chk("t4_post_ready", (W+1)'(in_ready), (W+1)'(1));
        chk("t4_post_busy", (W+1)'(busy), '0);
        chk("t4_post_valid", (W+1)'(out_valid), '0);
        chk("t4_post_res", out_res, '0);
        do_op(W'(32'h10), W'(32'h20), 0, LAT_SMALL, 1'b0, "t4op");
        chk("t4op_val", out_res, (W+1)'(32'h30));

        // Back-to-back with in_valid held high
        in_s = W'(1000);
        in_c = W'(234);
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        in_s = ones;
        in_c = W'(7);
        n = 0;
        while (!out_valid && n < 50) begin step(); n++; end
        chk("t5_a_res", out_res, (W+1)'(1234));
        step();
        chk("t5_gap_valid", (W+1)'(out_valid), '0);
        chk("t5_gap_ready", (W+1)'(in_ready), (W+1)'(1));
        step();
        in_valid = 1'b0;
        chk("t5_b_accepted", (W+1)'(in_ready), '0);
        n = 0;
        while (!out_valid && n < 50) begin step(); n++; end
        chk("t5_b_res", out_res, {1'b1, W'(6)});
        step();
        out_ready = 1'b0;
        chk("t5_b_hs", (W+1)'(out_valid), '0);

        // Early-exit sensitive latencies
        do_op(W'(5), W'(7), 0, LAT_SMALL, 1'b0, "t6a");
        chk("t6a_val", out_res, (W+1)'(12));
        do_op(b100, W'(0), 0, LAT_B100, 1'b0, "t6b");

        // Random operands with random backpressure
        for (int k = 0; k < 8; k++) begin
            s = rand_w();
            c = rand_w();
            if (k == 2) s[W-1:64] = '0;
            if (k == 2) c[W-1:64] = '0;
            do_op(s, c, int'($urandom_range(0, 3)), -1, 1'($urandom_range(0, 1)), "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
